// File: rtl/nn_pkg.sv
// Shared constants and types for the classifier result path
// (result_registers, result_argmax, avalon_interface).
package nn_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int DATA_W      = 16;
  localparam int SEL_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/result_argmax.sv
// Scans the class scores held in result_registers through the out_sel read
// port and reports the index and value of the largest signed score.
module result_argmax #(
  parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
  parameter int DATA_W      = nn_pkg::DATA_W,
  parameter int SEL_W       = nn_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [SEL_W-1:0]  class_idx,
  output logic [DATA_W-1:0] max_value
);

  import nn_pkg::*;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CLASSES - 1);

  // Full-width signed compare; strict so the lowest index wins on ties.
  function automatic logic score_gt(input logic signed [DATA_W-1:0] a,
                                    input logic signed [DATA_W-1:0] b);
    return a > b;
  endfunction

  argmax_state_t             state_q, state_d;
  logic [SEL_W-1:0]          cnt_q, cnt_d;
  logic [SEL_W-1:0]          class_idx_q, class_idx_d;
  logic signed [DATA_W-1:0]  max_value_q, max_value_d;
  logic                      result_valid_q, result_valid_d;
  logic signed [DATA_W-1:0]  score;

  assign score = $signed(out_data);

  // Next-state, scan counter and running-maximum update.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    class_idx_d    = class_idx_q;
    max_value_d    = max_value_q;
    result_valid_d = result_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = SCAN;
          cnt_d          = '0;
          result_valid_d = 1'b0;
        end
      end
      SCAN: begin
        // First score seeds the maximum so all-negative sets work.
        if ((cnt_q == '0) || score_gt(score, max_value_q)) begin
          max_value_d = score;
          class_idx_d = cnt_q;
        end
        if (cnt_q == LAST_IDX) begin
          state_d        = FINISH;
          cnt_d          = '0;
          result_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + SEL_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset also clears the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      class_idx_q    <= '0;
      max_value_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      class_idx_q    <= class_idx_d;
      max_value_q    <= max_value_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign out_sel      = (state_q == SCAN) ? cnt_q : '0;
  assign busy         = (state_q == SCAN);
  assign done         = (state_q == FINISH);
  assign result_valid = result_valid_q;
  assign class_idx    = class_idx_q;
  assign max_value    = max_value_q;

endmodule

// File: doc/result_argmax.md
Name: result_argmax

Overview:
- Downstream stage of result_registers: once main_controller raises done_calc, it scans the NUM_CLASSES row results through the out_sel read port.
- Finds the largest signed score and reports its class index and value to avalon_interface.
- Classification result is then readable by the host without a software argmax.

Parameters:
NUM_CLASSES, 10, number of result registers scanned (indices 0..NUM_CLASSES-1)
DATA_W, 16, width of each row_result / out_data word, two's complement signed
SEL_W, 4, width of out_sel and class_idx; must satisfy 2**SEL_W >= NUM_CLASSES

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  scan request, one-cycle pulse (driven from done_calc)
out_data  in  DATA_W  score from result_registers, combinational function of out_sel (same-cycle read)
out_sel  out  SEL_W  read select into result_registers
busy  out  1  high while a scan is in progress
done  out  1  one-cycle pulse when class_idx/max_value are updated
result_valid  out  1  sticky: a completed result is held on class_idx/max_value
class_idx  out  SEL_W  index of maximum score
max_value  out  DATA_W  maximum score (signed)

Behaviour:
- Reset (rst=1 at a clock edge, any state): state=IDLE, out_sel=0, busy=0, done=0, result_valid=0, class_idx=0, max_value=0, scan counter=0. Reset mid-scan aborts the scan: no done pulse, previous result discarded.
- States: IDLE, SCAN, FINISH.
- IDLE: out_sel=0.
  - start=1 sampled at edge E0 -> SCAN with counter=0, busy=1.
  - result_valid is cleared at E0; class_idx and max_value keep their old values until overwritten.
- SCAN: out_sel=counter.
  - At each edge, out_data is evaluated for index counter.
  - counter==0: max_value<=out_data and class_idx<=0 unconditionally. No comparison against the reset value, so all-negative score sets are handled.
  - counter>0: if $signed(out_data) > $signed(max_value), update both max_value and class_idx. Strictly greater, so on ties the lowest index wins.
  - counter==NUM_CLASSES-1: -> FINISH; otherwise counter++.
- FINISH (exactly one cycle): done=1, result_valid=1 (held), busy=0; -> IDLE at next edge.
- Latency: done is high in the cycle following edge E0+NUM_CLASSES, i.e. 10 edges after the start edge at default parameters. The next start can be sampled at the edge that ends the FINISH cycle.
- start while in SCAN or FINISH is ignored (no queueing, no restart).
- start and rst high at the same edge: rst wins.
- busy and done are never high in the same cycle; done is never high outside FINISH.
- Comparison is full DATA_W signed, with no saturation or widening. 0x8000 is the most negative value and is selected only if every score equals 0x8000 (then class_idx=0).
- Counter is SEL_W wide and never wraps past NUM_CLASSES-1.

Decomposition:
- Shared package nn_pkg holds:
  - NUM_CLASSES, DATA_W, SEL_W constants, also used by result_registers and avalon_interface.
  - argmax_state_t enum {IDLE, SCAN, FINISH}.
- No sub-module: FSM, counter and signed compare/update stay in one module.

Test Plan:
- Scores 0..9 (value=index), start pulse -> done exactly 10 edges after the start edge; class_idx=9, max_value=0x0009, result_valid=1.
- Score[3]=0x7FFF, others 0x0100 -> class_idx=3, max_value=0x7FFF. Check the out_sel sequence is 0,1,...,9, one per cycle.
- All negative: score[6]=0xFFFB (-5), others 0xFF9C (-100) -> class_idx=6, max_value=0xFFFB.
- Tie: score[2]=score[7]=0x0040, others 0x0010 -> class_idx=2. Also all scores 0x8000 -> class_idx=0, max_value=0x8000.
- Second start pulse four cycles into a scan -> ignored: single done pulse at the original time, result unchanged.
- rst asserted in the 5th SCAN cycle -> next cycle all outputs at reset values, no done pulse. A following start completes normally.
